// File: rtl/tl_pkg.sv
// Shared definitions for the traffic-light phase controller: state
// encodings, LED patterns per state and the default phase durations.
package tl_pkg;

  // State encodings, also driven out on the phase port
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_M_GREEN  = 3'd1;
  localparam logic [2:0] ST_M_YELLOW = 3'd2;
  localparam logic [2:0] ST_M_RED    = 3'd3;
  localparam logic [2:0] ST_S_YELLOW = 3'd4;
  localparam logic [2:0] ST_EMG      = 3'd5;

  // LED patterns: [5:3] main R/Y/G, [2:0] side R/Y/G
  localparam logic [5:0] LED_IDLE     = 6'b000_000;
  localparam logic [5:0] LED_M_GREEN  = 6'b001_100;
  localparam logic [5:0] LED_M_YELLOW = 6'b010_100;
  localparam logic [5:0] LED_M_RED    = 6'b100_001;
  localparam logic [5:0] LED_S_YELLOW = 6'b100_010;
  localparam logic [5:0] LED_EMG      = 6'b100_100;

  // Default phase durations in seconds
  localparam logic [7:0] DEF_MGREEN  = 8'd20;
  localparam logic [7:0] DEF_MYELLOW = 8'd3;
  localparam logic [7:0] DEF_MRED    = 8'd20;
  localparam logic [7:0] DEF_SYELLOW = 8'd3;
  localparam logic [7:0] DEF_PED     = 8'd5;

  // LED pattern shown while in a given state; unknown codes go dark
  function automatic logic [5:0] led_of(input logic [2:0] st);
    logic [5:0] pattern;
    case (st)
      ST_M_GREEN:  pattern = LED_M_GREEN;
      ST_M_YELLOW: pattern = LED_M_YELLOW;
      ST_M_RED:    pattern = LED_M_RED;
      ST_S_YELLOW: pattern = LED_S_YELLOW;
      ST_EMG:      pattern = LED_EMG;
      default:     pattern = LED_IDLE;
    endcase
    return pattern;
  endfunction

  // A zero duration would never expire, so it is stored as one second
  function automatic logic [7:0] dur_sanitize(input logic [7:0] d);
    return (d == 8'd0) ? 8'd1 : d;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Per-phase seconds counter: loads a duration on phase entry, counts down
// on each tick while above one, and flags expiry when a tick arrives at one.
module tl_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic       clear,
  input  logic [7:0] load_val,
  output logic [7:0] remain,
  output logic       expire
);

  // Expiry is purely the current count meeting a tick; the controller
  // decides what the next phase is and issues the matching load.
  assign expire = tick && (remain == 8'd1);

  // Count register: clear beats load beats decrement; never drops below one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain <= 8'd0;
    end else if (clear) begin
      remain <= 8'd0;
    end else if (load) begin
      remain <= load_val;
    end else if (tick && (remain > 8'd1)) begin
      remain <= remain - 8'd1;
    end
  end

endmodule

// File: rtl/tl_phase_ctrl.sv
// Traffic-light phase controller for a main/side road crossing.
// Cycles main green -> main yellow -> main red (side green) -> side yellow,
// with an emergency all-red override and runtime-writable durations.
// Optional build macro TL_PED_EN enables pedestrian green shortening.
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter logic [7:0] T_MGREEN  = DEF_MGREEN,
  parameter logic [7:0] T_MYELLOW = DEF_MYELLOW,
  parameter logic [7:0] T_MRED    = DEF_MRED,
  parameter logic [7:0] T_SYELLOW = DEF_SYELLOW,
  parameter logic [7:0] T_PED     = DEF_PED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1s,
  input  logic       ped_req,
  input  logic       emg_req,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic [5:0] led,
  output logic [7:0] remain,
  output logic [2:0] phase,
  output logic       ped_ack
);

  logic [2:0] state;
  logic [2:0] state_d;
  logic [7:0] dur_q [0:3];
  logic       load;
  logic       clear;
  logic [7:0] load_val;
  logic [7:0] green_val;
  logic       consume;
  logic       ped_eff;
  logic       timer_expire;

  tl_phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (tick_1s),
    .load     (load),
    .clear    (clear),
    .load_val (load_val),
    .remain   (remain),
    .expire   (timer_expire)
  );

`ifdef TL_PED_EN
  logic ped_pend;

  // A request acts on the same edge it is sampled, or later if it was held
  assign ped_eff = ped_pend | ped_req;

  // Pending request survives everything except being consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
    end else begin
      ped_pend <= ped_eff & ~consume;
      ped_ack  <= consume;
    end
  end
`else
  logic unused_ped;

  assign ped_eff    = 1'b0;
  assign ped_ack    = 1'b0;
  assign unused_ped = ^{ped_req, consume};
`endif

  // Duration registers; a write never affects a phase already running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q[0] <= T_MGREEN;
      dur_q[1] <= T_MYELLOW;
      dur_q[2] <= T_MRED;
      dur_q[3] <= T_SYELLOW;
    end else if (cfg_we) begin
      dur_q[cfg_addr] <= dur_sanitize(cfg_data);
    end
  end

  // Green load value, shortened when a pedestrian is waiting
  always_comb begin
    green_val = dur_q[0];
    if (ped_eff && (T_PED < dur_q[0])) begin
      green_val = T_PED;
    end
  end

  // Next-state and timer-command decode; emergency overrides everything
  always_comb begin
    state_d  = state;
    load     = 1'b0;
    clear    = 1'b0;
    load_val = 8'd0;
    consume  = 1'b0;
    if (state == ST_IDLE) begin
      state_d  = ST_M_GREEN;
      load     = 1'b1;
      load_val = green_val;
      consume  = ped_eff;
    end else if (emg_req) begin
      state_d = ST_EMG;
      clear   = 1'b1;
    end else begin
      case (state)
        ST_EMG: begin
          state_d  = ST_M_GREEN;
          load     = 1'b1;
          load_val = green_val;
          consume  = ped_eff;
        end
        ST_M_GREEN: begin
          if (timer_expire) begin
            state_d  = ST_M_YELLOW;
            load     = 1'b1;
            load_val = dur_q[1];
            consume  = ped_eff;
          end else if (ped_eff) begin
            consume = 1'b1;
            if (remain > T_PED) begin
              load     = 1'b1;
              load_val = T_PED;
            end
          end
        end
        ST_M_YELLOW: begin
          if (timer_expire) begin
            state_d  = ST_M_RED;
            load     = 1'b1;
            load_val = dur_q[2];
          end
        end
        ST_M_RED: begin
          if (timer_expire) begin
            state_d  = ST_S_YELLOW;
            load     = 1'b1;
            load_val = dur_q[3];
          end
        end
        ST_S_YELLOW: begin
          if (timer_expire) begin
            state_d  = ST_M_GREEN;
            load     = 1'b1;
            load_val = green_val;
            consume  = ped_eff;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State plus registered outputs, all taken from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      phase <= ST_IDLE;
      led   <= LED_IDLE;
    end else begin
      state <= state_d;
      phase <= state_d;
      led   <= led_of(state_d);
    end
  end

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Directed, self-checking bench for tl_phase_ctrl. Expected outputs are
// pushed to a scoreboard queue as stimulus is driven and popped when the
// DUT output is sampled. Pedestrian checks depend on TL_PED_EN.
module tb_tl_phase_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick_1s;
  logic       ped_req;
  logic       emg_req;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [5:0] led;
  logic [7:0] remain;
  logic [2:0] phase;
  logic       ped_ack;

  localparam logic [5:0] L_OFF = 6'b000_000;
  localparam logic [5:0] L_MG  = 6'b001_100;
  localparam logic [5:0] L_MY  = 6'b010_100;
  localparam logic [5:0] L_MR  = 6'b100_001;
  localparam logic [5:0] L_SY  = 6'b100_010;
  localparam logic [5:0] L_EMG = 6'b100_100;

  typedef struct {
    string       tag;
    logic [2:0]  ph;
    logic [5:0]  ld;
    logic [7:0]  rem;
    logic        ack;
  } exp_t;

  exp_t expQ[$];
  int   checkCount;
  int   passCount;
  int   failCount;

  tl_phase_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_1s  (tick_1s),
    .ped_req  (ped_req),
    .emg_req  (emg_req),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .led      (led),
    .remain   (remain),
    .phase    (phase),
    .ped_ack  (ped_ack)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always terminates
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Queue one expected output record
  task automatic pushExp(input string tag, input logic [2:0] ph, input logic [5:0] ld,
                         input logic [7:0] rem, input logic ack);
    exp_t e;
    e.tag = tag;
    e.ph  = ph;
    e.ld  = ld;
    e.rem = rem;
    e.ack = ack;
    expQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare it to the live DUT outputs
  task automatic checkOutput();
    exp_t e;
    logic [17:0] obs;
    logic [17:0] req;
    e   = expQ.pop_front();
    obs = {phase, led, remain, ped_ack};
    req = {e.ph, e.ld, e.rem, e.ack};
    checkCount++;
    assert (obs === req) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed phase=%0d led=%b remain=%0d ack=%b, expected phase=%0d led=%b remain=%0d ack=%b",
             e.tag, phase, led, remain, ped_ack, e.ph, e.ld, e.rem, e.ack);
    end
  endtask

  // Drive one clock cycle of inputs; pulses drop back after the edge
  task automatic applyStimulus(input logic tk, input logic we, input logic [1:0] addr,
                               input logic [7:0] data, input logic ped);
    tick_1s  = tk;
    cfg_we   = we;
    cfg_addr = addr;
    cfg_data = data;
    ped_req  = ped;
    @(posedge clk);
    #1;
    tick_1s = 1'b0;
    cfg_we  = 1'b0;
    ped_req = 1'b0;
  endtask

  // One second: three quiet cycles then a tick cycle
  task automatic oneSecond();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
  endtask

  // Check remain from 'from' down to stopAt+1, one second apart
  task automatic countDown(input string tag, input logic [2:0] ph, input logic [5:0] ld,
                           input int from, input int stopAt);
    for (int k = from; k > stopAt; k--) begin
      pushExp(tag, ph, ld, 8'(k), 1'b0);
      checkOutput();
      oneSecond();
    end
  endtask

  // Main directed sequence
  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    rst_n    = 1'b0;
    tick_1s  = 1'b0;
    ped_req  = 1'b0;
    emg_req  = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = 2'd0;
    cfg_data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    pushExp("reset_state", 3'd0, L_OFF, 8'd0, 1'b0);
    checkOutput();

    rst_n = 1'b1;
    pushExp("idle_after_release", 3'd0, L_OFF, 8'd0, 1'b0);
    checkOutput();
    pushExp("first_green", 3'd1, L_MG, 8'd20, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    checkOutput();

    countDown("cycle_mgreen", 3'd1, L_MG, 20, 0);
    countDown("cycle_myellow", 3'd2, L_MY, 3, 0);
    countDown("cycle_mred", 3'd3, L_MR, 20, 0);
    countDown("cycle_syellow", 3'd4, L_SY, 3, 0);

    pushExp("cfg_write_no_effect", 3'd1, L_MG, 8'd20, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd1, 8'd0, 1'b0);
    checkOutput();
    countDown("green_before_short_yellow", 3'd1, L_MG, 20, 0);
    pushExp("yellow_zero_stored_as_one", 3'd2, L_MY, 8'd1, 1'b0);
    checkOutput();
    oneSecond();

    countDown("red_to_seven", 3'd3, L_MR, 20, 7);
    pushExp("red_at_seven", 3'd3, L_MR, 8'd7, 1'b0);
    checkOutput();
    emg_req = 1'b1;
    pushExp("emg_enter", 3'd5, L_EMG, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    checkOutput();
    pushExp("emg_ignores_tick", 3'd5, L_EMG, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd0, 1'b0);
    checkOutput();
    emg_req = 1'b0;
    pushExp("emg_exit_green", 3'd1, L_MG, 8'd20, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    checkOutput();

    countDown("green_to_one", 3'd1, L_MG, 20, 1);
    pushExp("green_at_one", 3'd1, L_MG, 8'd1, 1'b0);
    checkOutput();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    pushExp("load_uses_prewrite", 3'd2, L_MY, 8'd1, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd1, 8'd4, 1'b0);
    checkOutput();
    oneSecond();

    countDown("red_before_reset", 3'd3, L_MR, 20, 0);
    pushExp("syellow_entry", 3'd4, L_SY, 8'd3, 1'b0);
    checkOutput();
    oneSecond();
    rst_n = 1'b0;
    #1;
    pushExp("async_reset_mid_syellow", 3'd0, L_OFF, 8'd0, 1'b0);
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushExp("green_after_reset", 3'd1, L_MG, 8'd20, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    checkOutput();
    countDown("green_after_reset_count", 3'd1, L_MG, 20, 0);
    pushExp("yellow_reverted_default", 3'd2, L_MY, 8'd3, 1'b0);
    checkOutput();

    countDown("yellow_to_red", 3'd2, L_MY, 3, 0);
    countDown("red_to_syellow", 3'd3, L_MR, 20, 0);
    countDown("syellow_to_green", 3'd4, L_SY, 3, 0);
    countDown("green_to_fifteen", 3'd1, L_MG, 20, 15);
`ifdef TL_PED_EN
    pushExp("ped_truncate", 3'd1, L_MG, 8'd5, 1'b1);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    checkOutput();
    pushExp("ped_ack_one_cycle", 3'd1, L_MG, 8'd5, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    checkOutput();
    countDown("ped_short_green", 3'd1, L_MG, 5, 0);
    countDown("ped_yellow", 3'd2, L_MY, 3, 0);
    pushExp("ped_req_in_red", 3'd3, L_MR, 8'd20, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    checkOutput();
    countDown("ped_red", 3'd3, L_MR, 20, 0);
    countDown("ped_syellow", 3'd4, L_SY, 3, 1);
    pushExp("ped_syellow_one", 3'd4, L_SY, 8'd1, 1'b0);
    checkOutput();
    oneSecond();
    pushExp("ped_deferred_green", 3'd1, L_MG, 8'd5, 1'b1);
    checkOutput();
    pushExp("ped_deferred_ack_drop", 3'd1, L_MG, 8'd5, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    checkOutput();
`else
    pushExp("ped_ignored", 3'd1, L_MG, 8'd15, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    checkOutput();
    pushExp("ped_still_ignored", 3'd1, L_MG, 8'd15, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0, 1'b0);
    checkOutput();
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tl_phase_ctrl.md
TL_PHASE_CTRL -- requirements
Module: tl_phase_ctrl

Interface
REQ-001 SHALL have parameter T_MGREEN, default 8'd20, main-green duration in seconds.
REQ-002 SHALL have parameter T_MYELLOW, default 8'd3, main-yellow duration in seconds.
REQ-003 SHALL have parameter T_MRED, default 8'd20, main-red/side-green duration in seconds.
REQ-004 SHALL have parameter T_SYELLOW, default 8'd3, side-yellow duration in seconds.
REQ-005 SHALL have parameter T_PED, default 8'd5, pedestrian-shortened green ceiling in seconds.
REQ-006 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-008 SHALL have port tick_1s  in  1  one-cycle pulse per second.
REQ-009 SHALL have port ped_req  in  1  debounced pedestrian key pulse.
REQ-010 SHALL have port emg_req  in  1  emergency level, synchronous to clk.
REQ-011 SHALL have ports cfg_we in 1, cfg_addr in 2 and cfg_data in 8, the duration-register write port (addr 0..3 = MGREEN, MYELLOW, MRED, SYELLOW).
REQ-012 SHALL have port led  out  6  bits [5:3] main R/Y/G, bits [2:0] side R/Y/G.
REQ-013 SHALL have port remain  out  8  seconds left in the current phase, for the display.
REQ-014 SHALL have port phase  out  3  current state encoding.
REQ-015 SHALL have port ped_ack  out  1  one-cycle pulse when a pedestrian request is consumed.

Function
REQ-016 SHALL implement states IDLE=0, M_GREEN=1, M_YELLOW=2, M_RED=3, S_YELLOW=4, EMG=5.
REQ-017 SHALL leave IDLE unconditionally on the first clock edge after reset, entering M_GREEN.
REQ-018 SHALL cycle M_GREEN->M_YELLOW->M_RED->S_YELLOW->M_GREEN.
REQ-019 SHALL load remain with the target phase's duration register on every phase entry.
REQ-020 SHALL decrement remain on each edge where tick_1s=1 and remain>1; where tick_1s=1 and remain==1, it SHALL change phase at that same edge.
REQ-021 SHALL register led and phase from the next state, so they change on the same edge as the state.
REQ-022 SHALL drive led as: IDLE 000_000; M_GREEN 001_100; M_YELLOW 010_100; M_RED 100_001; S_YELLOW 100_010; EMG 100_100.
REQ-023 SHALL enter EMG from any non-IDLE state on the edge emg_req is sampled high; this has priority over phase expiry and pedestrian handling.
REQ-024 SHALL hold remain=0 while in EMG and ignore tick_1s.
REQ-025 SHALL go EMG->M_GREEN with a fresh load on the first edge emg_req is sampled low.
REQ-026 SHALL update a duration register on cfg_we=1; cfg_data=0 is stored as 1; an out-of-range address cannot occur (2-bit address).
REQ-027 SHALL take a new duration effect only at the next entry to that phase; a load coinciding with a write to the same register uses the pre-write value.
REQ-028 SHALL keep remain and phase widths fixed at 8 and 3 bits; remain never wraps below 1 while counting.

Reset
REQ-029 SHALL, while rst_n=0, force: state IDLE, led 0, remain 0, phase 0, ped_ack 0, pedestrian-pending flag 0, duration registers = parameter defaults.
REQ-030 SHALL, on reset asserted mid-phase, abandon the phase; after release, M_GREEN is entered with a full load.

Configuration
REQ-031 SHALL provide macro TL_PED_EN; when defined: ped_req sets a pending flag (held through EMG); in M_GREEN with remain>T_PED, the flag truncates remain to T_PED on the next edge and pulses ped_ack; in M_GREEN with remain<=T_PED, the flag clears with ped_ack and no change; otherwise the flag applies on the next M_GREEN entry, loading min(MGREEN, T_PED).
REQ-032 SHALL, when TL_PED_EN is undefined, ignore ped_req, tie ped_ack to 0 and omit the pending flag.

Structure
REQ-033 SHALL place the state encodings, LED patterns and default durations in shared package tl_pkg.
REQ-034 SHALL implement the load/decrement/expire counter as sub-module tl_phase_timer.

Verification
REQ-035 SHALL cover: reset release, tick every 4 cycles -> IDLE, then M_GREEN with remain=20 and led=001_100; 20 ticks later M_YELLOW with remain=3.
REQ-036 SHALL cover: full cycle -> phase sequence 1,2,3,4,1; led patterns per REQ-022; remain counts 20..1, 3..1, 20..1, 3..1.
REQ-037 SHALL cover: emg_req high while M_RED remain=7 -> EMG next edge, led=100_100, remain=0; emg_req low -> M_GREEN, remain=20.
REQ-038 SHALL cover: cfg write addr1 data 0 during M_GREEN -> current remain unaffected; next M_YELLOW loads remain=1.
REQ-039 SHALL cover, with TL_PED_EN: ped_req at M_GREEN remain=15 -> remain=5 next edge, ped_ack one cycle; ped_req during M_RED -> next M_GREEN loads 5.
REQ-040 SHALL cover: rst_n low mid-S_YELLOW -> all outputs 0 immediately; after release, cfg-written values revert to defaults.
